// File: rtl/rvfi_wb_mem_pkg.sv
// Shared types and helpers for the rvfi_wb_mem_model Wishbone memory responder.
//   wb_port_state_e : per-port request FSM state
//   LAT_W           : width of the per-port wait counter
//   apply_sel       : merge the enabled bytes of a write into an existing word
package rvfi_wb_mem_pkg;

    localparam int LAT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } wb_port_state_e;

    function automatic logic [31:0] apply_sel(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  sel);
        logic [31:0] res;
        res = old_w;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) res[8*b +: 8] = new_w[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/rvfi_wb_mem_model_port_fsm.sv
// Per-port Wishbone request sequencer: latches a request, waits LAT cycles,
// pulses ack for one cycle and flags a cyc drop while a request is pending.
//   clock, reset       : system clock, synchronous active-high reset
//   cyc/adr/dat/sel/we : bus request inputs
//   ack                : registered one-cycle acknowledge
//   rd_stb             : read access enters ACK on the next edge (load rdt now)
//   wr_stb             : write access leaves ACK on the next edge (commit now)
//   req_*              : request latch as seen by the strobes
//   proto_err          : sticky protocol-violation flag
//
// state | meaning
// IDLE  | no request pending, sampling cyc
// WAIT  | request latched, counting down the extra latency
// ACK   | ack high for exactly this cycle
module wb_mem_port_fsm
    import rvfi_wb_mem_pkg::*;
#(
    parameter int LAT = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cyc,
    input  logic [31:0] adr,
    input  logic [31:0] dat,
    input  logic [3:0]  sel,
    input  logic        we,
    output logic        ack,
    output logic        rd_stb,
    output logic        wr_stb,
    output logic [31:0] req_adr,
    output logic [31:0] req_dat,
    output logic [3:0]  req_sel,
    output logic        proto_err
);

    if (LAT < 0 || LAT > 15) begin : g_bad_lat
        $error("wb_mem_port_fsm: LAT must be within 0..15");
    end

    localparam logic [LAT_W-1:0] LAT_V = LAT_W'(LAT);

    wb_port_state_e   state_q, state_d;
    logic [LAT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      adr_q, adr_d, dat_q, dat_d;
    logic [3:0]       sel_q, sel_d;
    logic             we_q, we_d;
    logic             ack_q, ack_d;
    logic             proto_q, proto_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        we_d    = we_q;
        proto_d = proto_q;
        case (state_q)
            IDLE: begin
                if (cyc) begin
                    adr_d   = adr;
                    dat_d   = dat;
                    sel_d   = sel;
                    we_d    = we;
                    cnt_d   = LAT_V;
                    state_d = (LAT == 0) ? ACK : WAIT;
                end
            end
            WAIT: begin
                if (!cyc) begin
                    state_d = IDLE;
                    proto_d = 1'b1;
                end else if (cnt_q == LAT_W'(1)) begin
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - LAT_W'(1);
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        ack_d = (state_d == ACK);
    end

    // The strobes are gated by reset so an aborted request never touches
    // the array or the read registers.
    assign rd_stb    = (state_d == ACK) && (state_q != ACK) && !we_d && !reset;
    assign wr_stb    = (state_q == ACK) && we_q && !reset;
    assign req_adr   = adr_d;
    assign req_dat   = dat_d;
    assign req_sel   = sel_d;
    assign ack       = ack_q;
    assign proto_err = proto_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            ack_q   <= 1'b0;
            proto_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            ack_q   <= ack_d;
            proto_q <= proto_d;
        end
    end

endmodule

// File: rtl/rvfi_wb_mem_model.sv
// Deterministic dual-port Wishbone memory for simulation and proof harnesses.
// One word array shared by a read-only instruction port and a byte-enabled
// data port, each with its own fixed ack latency.
//   clock, reset                       : system clock, synchronous active-high reset
//   ibus_adr/cyc -> ibus_rdt/ack       : instruction read port
//   dbus_adr/dat/sel/we/cyc -> rdt/ack : data read/write port
//   oob_err                            : sticky, access outside the mapped window
//   proto_err                          : sticky, cyc dropped while pending
module rvfi_wb_mem_model
    import rvfi_wb_mem_pkg::*;
#(
    parameter int          DEPTH_W   = 10,
    parameter int          ILAT      = 0,
    parameter int          DLAT      = 1,
    parameter logic [31:0] BASE      = 32'h0,
    parameter string       INIT_FILE = ""
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] ibus_adr,
    input  logic        ibus_cyc,
    output logic [31:0] ibus_rdt,
    output logic        ibus_ack,
    input  logic [31:0] dbus_adr,
    input  logic [31:0] dbus_dat,
    input  logic [3:0]  dbus_sel,
    input  logic        dbus_we,
    input  logic        dbus_cyc,
    output logic [31:0] dbus_rdt,
    output logic        dbus_ack,
    output logic        oob_err,
    output logic        proto_err
);

    localparam int NWORDS = 1 << DEPTH_W;

    logic [31:0] mem_q [NWORDS];

    initial begin
        for (int w = 0; w < NWORDS; w++) mem_q[w] = 32'h0;
    end

    logic        i_rd_stb, i_wr_stb, i_proto;
    logic [31:0] i_adr, i_dat;
    logic [3:0]  i_sel;
    logic        d_rd_stb, d_wr_stb, d_proto;
    logic [31:0] d_adr, d_dat;
    logic [3:0]  d_sel;

    wb_mem_port_fsm #(.LAT(ILAT)) u_ibus (
        .clock    (clock),
        .reset    (reset),
        .cyc      (ibus_cyc),
        .adr      (ibus_adr),
        .dat      (32'h0),
        .sel      (4'h0),
        .we       (1'b0),
        .ack      (ibus_ack),
        .rd_stb   (i_rd_stb),
        .wr_stb   (i_wr_stb),
        .req_adr  (i_adr),
        .req_dat  (i_dat),
        .req_sel  (i_sel),
        .proto_err(i_proto)
    );

    wb_mem_port_fsm #(.LAT(DLAT)) u_dbus (
        .clock    (clock),
        .reset    (reset),
        .cyc      (dbus_cyc),
        .adr      (dbus_adr),
        .dat      (dbus_dat),
        .sel      (dbus_sel),
        .we       (dbus_we),
        .ack      (dbus_ack),
        .rd_stb   (d_rd_stb),
        .wr_stb   (d_wr_stb),
        .req_adr  (d_adr),
        .req_dat  (d_dat),
        .req_sel  (d_sel),
        .proto_err(d_proto)
    );

    // Offsets below BASE wrap to large values, so one upper-bits test covers
    // both ends of the window.
    logic [31:0]        i_off, d_off;
    logic               i_hit, d_hit;
    logic [DEPTH_W-1:0] i_idx, d_idx;

    assign i_off = i_adr - BASE;
    assign d_off = d_adr - BASE;
    assign i_hit = (i_off[31:DEPTH_W+2] == '0);
    assign d_hit = (d_off[31:DEPTH_W+2] == '0);
    assign i_idx = i_off[DEPTH_W+1:2];
    assign d_idx = d_off[DEPTH_W+1:2];

    logic unused_sink;
    assign unused_sink = ^{i_wr_stb, i_dat, i_sel, i_off[1:0], d_off[1:0]};

    logic [31:0] ibus_rdt_q, ibus_rdt_d, dbus_rdt_q, dbus_rdt_d;
    logic        oob_q, oob_d;

    always_comb begin
        ibus_rdt_d = '0;
        dbus_rdt_d = '0;
        if (i_rd_stb && i_hit) ibus_rdt_d = mem_q[i_idx];
        if (d_rd_stb && d_hit) dbus_rdt_d = mem_q[d_idx];
        oob_d = oob_q | (i_rd_stb & ~i_hit) | ((d_rd_stb | d_wr_stb) & ~d_hit);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ibus_rdt_q <= '0;
            dbus_rdt_q <= '0;
            oob_q      <= 1'b0;
        end else begin
            ibus_rdt_q <= ibus_rdt_d;
            dbus_rdt_q <= dbus_rdt_d;
            oob_q      <= oob_d;
        end
    end

    // Array is deliberately outside reset; a read loaded on the commit edge
    // sees the old word.
    always_ff @(posedge clock) begin
        if (d_wr_stb && d_hit) mem_q[d_idx] <= apply_sel(mem_q[d_idx], d_dat, d_sel);
    end

    assign ibus_rdt  = ibus_rdt_q;
    assign dbus_rdt  = dbus_rdt_q;
    assign oob_err   = oob_q;
    assign proto_err = i_proto | d_proto;

endmodule
